multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 53 +++++
 rtl/mc_alu_decode.sv | 21 ++
 rtl/multicycle_control.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - opcodes, control encodings and FSM states (JUMP state exists only with MC_JUMP_EN)
package multicycle_control_pkg;

  // Supported opcodes
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  // ALU selection codes
  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  // ALU operand B sources
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC sources
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
`ifdef MC_JUMP_EN
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
`else
    S_BRANCH    = 4'd10
`endif
  } state_t;

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - immediate-instruction opcode to ALU selection
module mc_alu_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] i_op,
  output logic [2:0] o_alu_sel
);

  // Map the latched I-type opcode to its ALU operation; add is the safe fallback
  always_comb begin
    o_alu_sel = ALU_ADD;
    case (i_op)
      OP_ADDI: o_alu_sel = ALU_ADD;
      OP_ORI:  o_alu_sel = ALU_OR;
      OP_ANDI: o_alu_sel = ALU_AND;
      OP_SLTI: o_alu_sel = ALU_SLT;
      default: o_alu_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM (optional jump support under MC_JUMP_EN)
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluSel,
  output logic [1:0] pcSource,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic [2:0] w_imm_alu_sel;

  mc_alu_decode u_alu_decode (
    .i_op      (r_op),
    .o_alu_sel (w_imm_alu_sel)
  );

  // State register; opcode is captured only while in DECODE so later op changes are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= OP_R;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= op;
      end
    end
  end

  // Next-state and control outputs; reset forces every output low and returns to FETCH
  always_comb begin
    w_next      = r_state;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_REG;
    aluSel      = ALU_RTYPE;
    pcSource    = PCSRC_ALU;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    case (r_state)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        aluSel  = ALU_ADD;
        if (mem_ready) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMM_SH;
        aluSel  = ALU_ADD;
        case (op)
          OP_R:                             w_next = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: w_next = S_EXEC_I;
          OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
          OP_BEQ:                           w_next = S_BRANCH;
`ifdef MC_JUMP_EN
          OP_J:                             w_next = S_JUMP;
`endif
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        aluSel  = ALU_ADD;
        w_next  = (r_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (mem_ready) begin
          w_next = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        regWrite   = 1'b1;
        memToReg   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_EXEC_R: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_REG;
        aluSel  = ALU_RTYPE;
        w_next  = S_R_WB;
      end
      S_R_WB: begin
        regWrite   = 1'b1;
        regDst     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        aluSel  = w_imm_alu_sel;
        w_next  = S_I_WB;
      end
      S_I_WB: begin
        regWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluSrcB     = SRCB_REG;
        aluSel      = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
        w_next      = S_FETCH;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pcWrite    = 1'b1;
        pcSource   = PCSRC_JUMP;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase

    if (reset) begin
      w_next      = S_FETCH;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      memToReg    = 1'b0;
      regDst      = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = SRCB_REG;
      aluSel      = ALU_RTYPE;
      pcSource    = PCSRC_ALU;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control (jump cases follow MC_JUMP_EN)
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b0;
  logic       mem_ready = 1'b1;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluSel;
  logic [1:0] pcSource;
  logic       instr_done, illegal_op;

  int checks = 0;
  int errors = 0;

  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .mem_ready   (mem_ready),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .iorD        (iorD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .irWrite     (irWrite),
    .memToReg    (memToReg),
    .regDst      (regDst),
    .regWrite    (regWrite),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluSel      (aluSel),
    .pcSource    (pcSource),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  // Order: pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regDst regWrite aluSrcA aluSrcB aluSel pcSource instr_done illegal_op
  function automatic logic [18:0] v(input logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa,
                                    input logic [1:0] asb, input logic [2:0] sel, input logic [1:0] pcs,
                                    input logic done, ill);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, sel, pcs, done, ill};
  endfunction

  logic [18:0] ZERO, FETCH_RDY, FETCH_STALL, DECODE, DECODE_ILL, MEM_ADDR, MEM_READ, MEM_WB;
  logic [18:0] MEM_WRITE_RDY, MEM_WRITE_STALL, EXEC_R, R_WB, I_WB, BRANCH, JUMP;

  task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs after the edge, queue the expected outputs, compare at the falling edge
  task automatic cyc(input string tag, input logic rst, input logic mr, input logic [5:0] o,
                     input logic [18:0] ex);
    logic [18:0] obs;
    @(posedge clk);
    #1;
    reset = rst;
    mem_ready = mr;
    op = o;
    exp_q.push_back(ex);
    @(negedge clk);
    obs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite,
           aluSrcA, aluSrcB, aluSel, pcSource, instr_done, illegal_op};
    check_eq(tag, obs, exp_q.pop_front());
  endtask

  task automatic run_imm(input string tag, input logic [5:0] o, input logic [2:0] sel);
    cyc({tag, "_fetch"}, 0, 1, 6'b111111, FETCH_RDY);
    cyc({tag, "_decode"}, 0, 1, o, DECODE);
    cyc({tag, "_exec"}, 0, 1, 6'b100011, v(0,0,0,0,0,0,0,0,0,1, 2'b10, sel, 2'b00, 0,0));
    cyc({tag, "_wb"}, 0, 1, 6'b000100, I_WB);
  endtask

  initial begin
    ZERO            = v(0,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
    FETCH_RDY       = v(1,0,0,1,0,1,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);
    FETCH_STALL     = v(0,0,0,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);
    DECODE          = v(0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0,0);
    DECODE_ILL      = v(0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 1,1);
    MEM_ADDR        = v(0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0);
    MEM_READ        = v(0,0,1,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
    MEM_WB          = v(0,0,0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 1,0);
    MEM_WRITE_RDY   = v(0,0,1,0,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 1,0);
    MEM_WRITE_STALL = v(0,0,1,0,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
    EXEC_R          = v(0,0,0,0,0,0,0,0,0,1, 2'b00, 3'b000, 2'b00, 0,0);
    R_WB            = v(0,0,0,0,0,0,0,1,1,0, 2'b00, 3'b000, 2'b00, 1,0);
    I_WB            = v(0,0,0,0,0,0,0,0,1,0, 2'b00, 3'b000, 2'b00, 1,0);
    BRANCH          = v(0,1,0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 1,0);
    JUMP            = v(1,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 1,0);

    cyc("reset0", 1, 1, 6'b001000, ZERO);
    cyc("reset1", 1, 0, 6'b101011, ZERO);

    run_imm("addi", 6'b001000, 3'b010);
    run_imm("ori",  6'b001101, 3'b001);
    run_imm("andi", 6'b001100, 3'b011);
    run_imm("slti", 6'b001010, 3'b111);

    cyc("r_fetch",  0, 1, 6'b001101, FETCH_RDY);
    cyc("r_decode", 0, 1, 6'b000000, DECODE);
    cyc("r_exec",   0, 1, 6'b101011, EXEC_R);
    cyc("r_wb",     0, 1, 6'b111111, R_WB);

    cyc("lw_fetch",  0, 1, 6'b000000, FETCH_RDY);
    cyc("lw_decode", 0, 1, 6'b100011, DECODE);
    cyc("lw_addr",   0, 1, 6'b101011, MEM_ADDR);
    cyc("lw_read0",  0, 0, 6'b101011, MEM_READ);
    cyc("lw_read1",  0, 0, 6'b000100, MEM_READ);
    cyc("lw_read2",  0, 1, 6'b000000, MEM_READ);
    cyc("lw_wb",     0, 1, 6'b000000, MEM_WB);

    cyc("sw_fetch",  0, 1, 6'b100011, FETCH_RDY);
    cyc("sw_decode", 0, 1, 6'b101011, DECODE);
    cyc("sw_addr",   0, 1, 6'b100011, MEM_ADDR);
    cyc("sw_write",  0, 1, 6'b100011, MEM_WRITE_RDY);

    cyc("beq_fetch",  0, 1, 6'b000000, FETCH_RDY);
    cyc("beq_decode", 0, 1, 6'b000100, DECODE);
    cyc("beq_branch", 0, 1, 6'b000000, BRANCH);

    cyc("ill_fetch",  0, 1, 6'b000000, FETCH_RDY);
    cyc("ill_decode", 0, 1, 6'b111111, DECODE_ILL);

    cyc("stall_fetch0", 0, 0, 6'b000000, FETCH_STALL);
    cyc("stall_fetch1", 0, 0, 6'b000000, FETCH_STALL);
    cyc("stall_fetch2", 0, 1, 6'b000000, FETCH_RDY);
    cyc("stall_decode", 0, 1, 6'b000100, DECODE);
    cyc("stall_branch", 0, 1, 6'b000000, BRANCH);

    cyc("j_fetch", 0, 1, 6'b000000, FETCH_RDY);
`ifdef MC_JUMP_EN
    cyc("j_decode", 0, 1, 6'b000010, DECODE);
    cyc("j_jump",   0, 1, 6'b000000, JUMP);
`else
    cyc("j_decode", 0, 1, 6'b000010, DECODE_ILL);
`endif

    cyc("rst_sw_fetch",  0, 1, 6'b000000, FETCH_RDY);
    cyc("rst_sw_decode", 0, 1, 6'b101011, DECODE);
    cyc("rst_sw_addr",   0, 1, 6'b101011, MEM_ADDR);
    cyc("rst_sw_stall",  0, 0, 6'b101011, MEM_WRITE_STALL);
    cyc("rst_sw_reset",  1, 0, 6'b101011, ZERO);
    cyc("rst_sw_after",  0, 1, 6'b101011, FETCH_RDY);
    cyc("rst_sw_decode2", 0, 1, 6'b001000, DECODE);
    cyc("rst_sw_exec2",  0, 1, 6'b000000, v(0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0));
    cyc("rst_sw_wb2",    0, 1, 6'b000000, I_WB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
